// File: rtl/alu_op_sequencer.sv
// Initiator for a combinational ALU: accepts a request, holds operands for a
// programmable settle time, captures the result and returns it with flags.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned OP_W          = 3,
  parameter int unsigned MAX_OP        = 5,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [15:0]      txn_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TXN_W = 16;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   alu_a_next, alu_b_next, resp_result_next;
  logic [OP_W-1:0]    alu_op_next;
  logic               resp_valid_next, resp_zero_next, resp_err_next;
  logic [TXN_W-1:0]   txn_count_next;

  // Ready is a pure decode of the state; reset masks it immediately.
  assign req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      txn_count   <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      alu_a       <= alu_a_next;
      alu_b       <= alu_b_next;
      alu_op      <= alu_op_next;
      resp_valid  <= resp_valid_next;
      resp_result <= resp_result_next;
      resp_zero   <= resp_zero_next;
      resp_err    <= resp_err_next;
      txn_count   <= txn_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    alu_a_next       = alu_a;
    alu_b_next       = alu_b;
    alu_op_next      = alu_op;
    resp_valid_next  = resp_valid;
    resp_result_next = resp_result;
    resp_zero_next   = resp_zero;
    resp_err_next    = resp_err;
    txn_count_next   = txn_count;

    case (state)
      IDLE: begin
        if (req_valid) begin
          // Unsupported op codes never reach the ALU; answer with an error at once.
          if (32'(req_op) > MAX_OP) begin
            resp_result_next = '0;
            resp_zero_next   = 1'b1;
            resp_err_next    = 1'b1;
            resp_valid_next  = 1'b1;
            state_next       = RESP;
          end else begin
            alu_a_next  = req_a;
            alu_b_next  = req_b;
            alu_op_next = req_op;
            cnt_next    = '0;
            state_next  = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          resp_result_next = alu_result;
          resp_zero_next   = (alu_result == '0);
          resp_err_next    = 1'b0;
          resp_valid_next  = 1'b1;
          state_next       = RESP;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_valid_next = 1'b0;
          txn_count_next  = txn_count + TXN_W'(1);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU on its operand bus.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err;
  logic [15:0] txn_count;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .OP_W(3), .MAX_OP(5), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .txn_count(txn_count)
  );

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op);
    exp_t e;
    if (op > 3'd5) begin
      e.result = 32'h0; e.zero = 1'b1; e.err = 1'b1;
    end else begin
      e.result = alu_model(a, b, op);
      e.zero   = (e.result == 32'h0);
      e.err    = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    sb.push_back(expect_of(a, b, op));
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_accept_timeout req_ready=%b expected=1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Edges after the accept edge until resp_valid is seen (bounded).
  task automatic wait_resp(output int edges);
    edges = 0;
    while (!resp_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_op, resp_valid, resp_result, resp_zero, resp_err, txn_count, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs alu_a=%h alu_b=%h op=%0d rv=%b rr=%h z=%b e=%b txn=%h rdy=%b expected all 0",
               alu_a, alu_b, alu_op, resp_valid, resp_result, resp_zero, resp_err, txn_count, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready req_ready=%b expected=1", req_ready);
    end
  endtask

  task automatic test_or();
    int   edges;
    exp_t e;
    send_req(32'hF0F0_0000, 32'h0000_0F0F, 3'd1);
    wait_resp(edges);
    checks++;
    if (edges !== 2) begin
      failures++;
      $display("FAIL or_latency edges=%0d expected=2", edges);
    end
    e = sb.pop_front();
    checks++;
    if ({resp_result, resp_zero, resp_err} !== {e.result, e.zero, e.err} || e.result !== 32'hF0F0_0F0F) begin
      failures++;
      $display("FAIL or_payload got=%h/%b/%b expected=%h/%b/%b", resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
    end
    finish_resp();
    checks++;
    if ({resp_valid, req_ready, txn_count} !== {1'b0, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL or_complete rv=%b rdy=%b txn=%0d expected 0/1/1", resp_valid, req_ready, txn_count);
    end
  endtask

  task automatic test_zero_hold();
    int   edges;
    exp_t e;
    send_req(32'h0, 32'h0, 3'd1);
    wait_resp(edges);
    e = sb.pop_front();
    checks++;
    if ({resp_valid, resp_result, resp_zero, resp_err} !== {1'b1, e.result, e.zero, e.err}) begin
      failures++;
      $display("FAIL zero_payload got=%b/%h/%b/%b expected=1/%h/%b/%b", resp_valid, resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
    end
    // A competing request must be ignored while the response is stalled.
    req_a = 32'hAAAA_5555; req_b = 32'h1; req_op = 3'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_result, resp_zero, resp_err} !== {1'b1, 1'b0, e.result, e.zero, e.err}) begin
        failures++;
        $display("FAIL hold_cycle%0d rv=%b rdy=%b res=%h z=%b e=%b expected 1/0/%h/%b/%b", i, resp_valid, req_ready, resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
      end
    end
    req_valid = 1'b0;
    checks++;
    if ({alu_a, alu_op} !== {32'h0, 3'd1}) begin
      failures++;
      $display("FAIL hold_no_reload alu_a=%h alu_op=%0d expected 0/1", alu_a, alu_op);
    end
    finish_resp();
    checks++;
    if (txn_count !== 16'd2) begin
      failures++;
      $display("FAIL zero_txn txn=%0d expected=2", txn_count);
    end
  endtask

  task automatic test_bad_op();
    int   edges;
    exp_t e;
    send_req(32'h1234_5678, 32'h9ABC_DEF0, 3'd7);
    wait_resp(edges);
    checks++;
    if (edges !== 0) begin
      failures++;
      $display("FAIL badop_latency edges=%0d expected=0", edges);
    end
    e = sb.pop_front();
    checks++;
    if ({resp_result, resp_zero, resp_err} !== {e.result, e.zero, e.err}) begin
      failures++;
      $display("FAIL badop_payload got=%h/%b/%b expected=%h/%b/%b", resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {32'h0, 32'h0, 3'd1}) begin
      failures++;
      $display("FAIL badop_alu_held a=%h b=%h op=%0d expected 0/0/1", alu_a, alu_b, alu_op);
    end
    finish_resp();
    checks++;
    if (txn_count !== 16'd3) begin
      failures++;
      $display("FAIL badop_txn txn=%0d expected=3", txn_count);
    end
  endtask

  task automatic test_back_to_back();
    int          edges;
    exp_t        e;
    logic [31:0] a, b;
    logic [2:0]  op;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      b  = (i == 3) ? a : $urandom;
      op = (i == 3) ? 3'd4 : 3'($urandom_range(0, 7));
      send_req(a, b, op);
      wait_resp(edges);
      e = sb.pop_front();
      checks++;
      if ({resp_valid, resp_result, resp_zero, resp_err} !== {1'b1, e.result, e.zero, e.err}) begin
        failures++;
        $display("FAIL b2b_%0d op=%0d got=%b/%h/%b/%b expected=1/%h/%b/%b", i, op, resp_valid, resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({txn_count, resp_valid} !== {16'd13, 1'b0}) begin
      failures++;
      $display("FAIL b2b_txn txn=%0d rv=%b expected 13/0", txn_count, resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int   edges;
    int   seen = 0;
    exp_t e;
    send_req(32'h1, 32'h2, 3'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0 || txn_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_drop resp_valid_cycles=%0d txn=%0d expected 0/0", seen, txn_count);
    end
    send_req(32'h5, 32'h3, 3'd3);
    wait_resp(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== 2 || {resp_result, resp_zero, resp_err} !== {e.result, e.zero, e.err}) begin
      failures++;
      $display("FAIL reset_mid_after edges=%0d got=%h/%b/%b expected 2 %h/%b/%b", edges, resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
    end
    finish_resp();
    checks++;
    if (txn_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_mid_txn txn=%0d expected=1", txn_count);
    end
  endtask

  task automatic test_wrap();
    int   edges;
    exp_t e;
    force dut.txn_count = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count;
    @(negedge clk);
    send_req(32'h3, 32'h3, 3'd0);
    wait_resp(edges);
    e = sb.pop_front();
    checks++;
    if ({resp_result, resp_zero, resp_err} !== {e.result, e.zero, e.err}) begin
      failures++;
      $display("FAIL wrap_payload got=%h/%b/%b expected=%h/%b/%b", resp_result, resp_zero, resp_err, e.result, e.zero, e.err);
    end
    finish_resp();
    checks++;
    if (txn_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_txn txn=%h expected=0000", txn_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_or();
    test_zero_hold();
    test_bad_op();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover size=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
